// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, on magnitudes with a final sign fix-up.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic            flush,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [XLEN-1:0]   acc_hi, acc_lo, hi_next, lo_next;
    logic [XLEN-1:0]   mag, mag_next;
    logic [2:0]        op_q, op_next;
    logic              neg_a, neg_b, neg_a_next, neg_b_next;
    logic [XLEN-1:0]   result_next;
    logic              done_next;

    logic              a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     mul_sum, div_shift;
    logic [XLEN-1:0]   div_sub, step_hi, step_lo;
    logic              div_ge;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_val;

    assign stall_req = rst & start & ~done & ~flush;

    // Operand decode on the live inputs; only consumed in IDLE.
    always_comb begin
        a_signed = op[2] ? ~op[0] : (op != 3'b011);
        b_signed = op[2] ? ~op[0] : ~op[1];
        sa       = a_signed & opa[XLEN-1];
        sb       = b_signed & opb[XLEN-1];
        abs_a    = sa ? -opa : opa;
        abs_b    = sb ? -opb : opb;
        div_zero = op[2] && (opb == '0);
        div_ovf  = op[2] && !op[0] && (opa == {1'b1, {(XLEN-1){1'b0}}}) && (opb == '1);
    end

    // One iteration step: mul shifts {hi,lo} right adding mag; div shifts left and trial-subtracts mag.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : {(XLEN+1){1'b0}});
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, mag};
        div_sub   = div_shift[XLEN-1:0] - mag;
        if (op_q[2]) begin
            step_hi = div_ge ? div_sub : div_shift[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
        prod_fix = (neg_a ^ neg_b) ? -{step_hi, step_lo} : {step_hi, step_lo};
        quo_fix  = (neg_a ^ neg_b) ? -step_lo : step_lo;
        rem_fix  = neg_a ? -step_hi : step_hi;
        case (op_q)
            3'b000:                 final_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_val = quo_fix;
            default:                final_val = rem_fix;
        endcase
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        hi_next     = acc_hi;
        lo_next     = acc_lo;
        mag_next    = mag;
        op_next     = op_q;
        neg_a_next  = neg_a;
        neg_b_next  = neg_b;
        result_next = result;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    op_next    = op;
                    neg_a_next = sa;
                    neg_b_next = sb;
                    if (div_zero || div_ovf) begin
                        if (div_zero)
                            result_next = op[1] ? opa : '1;
                        else
                            result_next = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        hi_next    = '0;
                        lo_next    = op[2] ? abs_a : abs_b;
                        mag_next   = op[2] ? abs_b : abs_a;
                        cnt_next   = '0;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (flush || !start) begin
                    state_next = IDLE;
                end else begin
                    hi_next  = step_hi;
                    lo_next  = step_lo;
                    cnt_next = cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1)) begin
                        result_next = final_val;
                        done_next   = 1'b1;
                        state_next  = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mag    <= '0;
            op_q   <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            acc_hi <= hi_next;
            acc_lo <= lo_next;
            mag    <= mag_next;
            op_q   <= op_next;
            neg_a  <= neg_a_next;
            neg_b  <= neg_b_next;
            result <= result_next;
            done   <= done_next;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table for results/latency plus flush, reset and back-to-back sequences.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] opa, opb;
    logic        stall_req, done;
    logic [31:0] result;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .flush(flush), .stall_req(stall_req), .done(done), .result(result)
    );

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] e, input int l, input string n);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = l; v.name = n;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Issues one op from IDLE and counts edges until done, checking stall_req on the way.
    task automatic apply_stimulus(input vec_t v);
        int   edges;
        bit   seen;
        logic stall_ok;
        @(negedge clk);
        op = v.op; opa = v.a; opb = v.b; start = 1'b1; flush = 1'b0;
        #1 stall_ok = (stall_req === 1'b1);
        edges = 0;
        seen  = 0;
        while (!seen && edges < 40) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (done === 1'b1) begin
                seen = 1;
                if (stall_req !== 1'b0) stall_ok = 1'b0;
            end else if (stall_req !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        check_output({v.name, " latency"}, seen ? edges : 0, v.lat);
        check_output({v.name, " result"}, result, v.exp);
        check_output({v.name, " stall"}, {31'b0, stall_ok}, 32'd1);
        start = 1'b0;
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) hits++;
        end
        check_output(name, hits, 0);
    endtask

    initial begin
        int first_done, second_done, edge_n;
        bit back_to_back;
        logic prev_done;

        rst = 1'b0; start = 1'b1; flush = 1'b0; op = 3'b000; opa = 32'd7; opb = 32'd3;
        #12;
        check_output("reset stall_req", {31'b0, stall_req}, 32'd0);
        check_output("reset done", {31'b0, done}, 32'd0);
        check_output("reset result", result, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        vecs.push_back(mk(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "MUL 7*-3"));
        vecs.push_back(mk(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "MULHU max"));
        vecs.push_back(mk(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "MULH min*min"));
        vecs.push_back(mk(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "MULHSU -1*max"));
        vecs.push_back(mk(3'b001, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 33, "MULH -7*3"));
        vecs.push_back(mk(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "DIV -7/2"));
        vecs.push_back(mk(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "REM -7/2"));
        vecs.push_back(mk(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, "DIV 7/-2"));
        vecs.push_back(mk(3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33, "REM 7/-2"));
        vecs.push_back(mk(3'b101, 32'd10,       32'd3,        32'd3,        33, "DIVU 10/3"));
        vecs.push_back(mk(3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, "DIVU max/1"));
        vecs.push_back(mk(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        33, "REMU max/max-1"));
        vecs.push_back(mk(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "DIVU by 0"));
        vecs.push_back(mk(3'b111, 32'h1234,     32'd0,        32'h1234,     1,  "REMU by 0"));
        vecs.push_back(mk(3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1,  "DIV by 0"));
        vecs.push_back(mk(3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1,  "REM by 0"));
        vecs.push_back(mk(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "DIV overflow"));
        vecs.push_back(mk(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "REM overflow"));

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Flush ten cycles into a multiply: no done, result keeps the previous value.
        @(negedge clk);
        op = 3'b000; opa = 32'd5; opb = 32'd6; start = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1 check_output("flush stall_req", {31'b0, stall_req}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check_output("flush no done", {31'b0, done}, 32'd0);
        watch_no_done("flush quiet", 40);
        check_output("flush result held", result, 32'd0);
        apply_stimulus(mk(3'b000, 32'd3, 32'd4, 32'd12, 33, "MUL 3*4 after flush"));

        // Reset five cycles into a divide.
        @(negedge clk);
        op = 3'b101; opa = 32'd100; opb = 32'd7; start = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("midreset done", {31'b0, done}, 32'd0);
        check_output("midreset result", result, 32'd0);
        check_output("midreset stall_req", {31'b0, stall_req}, 32'd0);
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        watch_no_done("midreset quiet", 40);
        apply_stimulus(mk(3'b101, 32'd100, 32'd7, 32'd14, 33, "DIVU 100/7 after reset"));

        // Back-to-back MUL then REMU with start held across the boundary.
        @(negedge clk);
        op = 3'b000; opa = 32'd2; opb = 32'd3; start = 1'b1;
        first_done = 0; second_done = 0; back_to_back = 0; prev_done = 1'b0;
        edge_n = 0;
        while (second_done == 0 && edge_n < 90) begin
            @(posedge clk);
            @(negedge clk);
            edge_n++;
            if (done === 1'b1 && prev_done === 1'b1) back_to_back = 1;
            prev_done = done;
            if (done === 1'b1) begin
                if (first_done == 0) begin
                    first_done = edge_n;
                    check_output("b2b MUL result", result, 32'd6);
                    op = 3'b111; opa = 32'd100; opb = 32'd7;
                end else begin
                    second_done = edge_n;
                    check_output("b2b REMU result", result, 32'd2);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check_output("b2b first done", first_done, 33);
        check_output("b2b second done", second_done, 67);
        check_output("b2b done single", {31'b0, back_to_back}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
